// File: rtl/addsub_pkg.sv
// ---------------------------------------------------------------------------
// addsub_pkg
//
// Shared types for the add/subtract pipeline with flags.
//   op_e     : two-bit operation select carried alongside each operand beat
//   flags_t  : zero / sign / carry-borrow / parity / signed-overflow bundle
//   helpers  : decode of an op into "is subtract" and "uses stored carry"
// ---------------------------------------------------------------------------
package addsub_pkg;

  // Legal operand width range for the pipeline.
  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 64;

  // Operation encoding; the numeric values match the in_op pins directly.
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  // Result flags in a fixed order so they can be registered as one vector.
  typedef struct packed {
    logic z;
    logic s;
    logic c;
    logic p;
    logic o;
  } flags_t;

  // SUB and SBB both run through the adder with an inverted b operand.
  function automatic logic isSubOp(input op_e op);
    return (op == OP_SUB) || (op == OP_SBB);
  endfunction

  // ADC and SBB consume the stored carry flag as part of the carry-in.
  function automatic logic usesCarry(input op_e op);
    return (op == OP_ADC) || (op == OP_SBB);
  endfunction

endpackage

// File: rtl/addsub_flags_pipe_flag_gen.sv
// ---------------------------------------------------------------------------
// flag_gen
//
// Purely combinational flag generator for one adder result.
//
// Parameters
//   WIDTH       operand / result width
//   PARITY_ODD  1: p high for an odd count of ones, 0: p high for even count
//
// Ports
//   i_sum       adder result, already reduced modulo 2^WIDTH
//   i_carryOut  raw carry out of the adder's top bit
//   i_aMsb      sign bit of operand a
//   i_bMsb      sign bit of operand b as presented on the input (not inverted)
//   i_isSub     1 when the adder was fed ~b (SUB / SBB)
//   o_flags     {z, s, c, p, o}
// ---------------------------------------------------------------------------
module flag_gen
  import addsub_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int PARITY_ODD = 1
) (
  input  logic [WIDTH-1:0] i_sum,
  input  logic             i_carryOut,
  input  logic             i_aMsb,
  input  logic             i_bMsb,
  input  logic             i_isSub,
  output flags_t           o_flags
);

  logic w_effBMsb;
  logic w_xorReduce;

  // The adder saw ~b for subtracts, so overflow must be judged against the
  // sign of the operand it actually added. For subtracts the carry flag is
  // the borrow, which is the inverted carry out of a + ~b + cin.
  always_comb begin
    w_effBMsb   = i_bMsb ^ i_isSub;
    w_xorReduce = ^i_sum;

    o_flags   = '0;
    o_flags.z = (i_sum == '0);
    o_flags.s = i_sum[WIDTH-1];
    o_flags.c = i_carryOut ^ i_isSub;
    o_flags.p = (PARITY_ODD != 0) ? w_xorReduce : ~w_xorReduce;
    o_flags.o = (i_aMsb == w_effBMsb) && (i_sum[WIDTH-1] != i_aMsb);
  end

endmodule

// File: rtl/addsub_flags_pipe.sv
// ---------------------------------------------------------------------------
// addsub_flags_pipe
//
// Two-stage valid/ready add/subtract unit with flags, a stored carry for
// multi-word ADC/SBB chains and a sticky signed-overflow flag.
//
//   Stage 1 (S1) : registers operands and op on an input handshake.
//   Stage 2 (S2) : computes a + b' + cin from S1 and registers result+flags.
//
// Parameters
//   WIDTH       operand / result width, legal range 4..64
//   PARITY_ODD  1: out_p high for odd count of ones, 0: for even count
//
// Ports
//   clk, rst                  clock and synchronous active-high reset
//   in_valid / in_ready       input handshake
//   in_a, in_b, in_op         operands and op (00 ADD, 01 SUB, 10 ADC, 11 SBB)
//   out_valid / out_ready     output handshake
//   out_sum                   result modulo 2^WIDTH
//   out_z/s/c/p/o             zero, sign, carry/borrow, parity, overflow
//   carry_flag                stored C used by ADC / SBB
//   ovf_sticky, clr_sticky    accumulated overflow and its clear
// ---------------------------------------------------------------------------
module addsub_flags_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int PARITY_ODD = 1
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,

  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_z,
  output logic             out_s,
  output logic             out_c,
  output logic             out_p,
  output logic             out_o,

  output logic             carry_flag,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);

  // Stage 1 registers.
  logic             r_s1Valid;
  logic [WIDTH-1:0] r_s1A;
  logic [WIDTH-1:0] r_s1B;
  op_e              r_s1Op;

  // Stage 2 (output) registers.
  logic             r_outValid;
  logic [WIDTH-1:0] r_outSum;
  flags_t           r_outFlags;

  // Architectural state shared across beats.
  logic             r_carryFlag;
  logic             r_ovfSticky;

  // Handshake / datapath wires.
  logic             w_s2Load;
  logic             w_inReady;
  logic             w_inAccept;
  logic             w_isSub;
  logic             w_cin;
  logic [WIDTH-1:0] w_bEff;
  logic [WIDTH:0]   w_full;
  flags_t           w_flags;

  // S2 takes S1's beat whenever S2 is empty or its beat leaves this cycle.
  // S1 may then refill in the same cycle, which keeps one beat per cycle
  // flowing. in_ready only looks at registered state, out_ready and rst,
  // never at in_valid, and is forced low while reset is held.
  always_comb begin
    w_s2Load   = r_s1Valid && (!r_outValid || out_ready);
    w_inReady  = !rst && (!r_s1Valid || w_s2Load);
    w_inAccept = in_valid && w_inReady;
  end

  // Adder front end. Subtracts become a + ~b + cin; for SBB the carry-in is
  // the inverse of the stored borrow. The stored carry is read here while
  // the previous beat's flag is already registered, so back-to-back chained
  // beats see the right C without a bubble.
  always_comb begin
    w_isSub = isSubOp(r_s1Op);
    w_bEff  = w_isSub ? ~r_s1B : r_s1B;
    w_cin   = 1'b0;
    case (r_s1Op)
      OP_ADD:  w_cin = 1'b0;
      OP_SUB:  w_cin = 1'b1;
      OP_ADC:  w_cin = r_carryFlag;
      OP_SBB:  w_cin = !r_carryFlag;
      default: w_cin = 1'b0;
    endcase
    w_full = {1'b0, r_s1A} + {1'b0, w_bEff} + (WIDTH+1)'(w_cin);
  end

  flag_gen #(
    .WIDTH      (WIDTH),
    .PARITY_ODD (PARITY_ODD)
  ) u_flagGen (
    .i_sum      (w_full[WIDTH-1:0]),
    .i_carryOut (w_full[WIDTH]),
    .i_aMsb     (r_s1A[WIDTH-1]),
    .i_bMsb     (r_s1B[WIDTH-1]),
    .i_isSub    (w_isSub),
    .o_flags    (w_flags)
  );

  // Stage 1: captures a beat on every input handshake. When S1 is able to
  // load but nothing is offered, it simply becomes empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1A     <= '0;
      r_s1B     <= '0;
      r_s1Op    <= OP_ADD;
    end else begin
      if (w_inReady) begin
        r_s1Valid <= in_valid;
      end
      if (w_inAccept) begin
        r_s1A  <= in_a;
        r_s1B  <= in_b;
        r_s1Op <= op_e'(in_op);
      end
    end
  end

  // Stage 2: result and flags only change when a new beat loads, so they
  // stay stable across a downstream stall. The stored carry follows every
  // loaded result in order, chained or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid  <= 1'b0;
      r_outSum    <= '0;
      r_outFlags  <= '0;
      r_carryFlag <= 1'b0;
    end else if (w_s2Load) begin
      r_outValid  <= 1'b1;
      r_outSum    <= w_full[WIDTH-1:0];
      r_outFlags  <= w_flags;
      r_carryFlag <= w_flags.c;
    end else if (out_ready) begin
      r_outValid  <= 1'b0;
    end
  end

  // Sticky overflow: a loading overflow takes priority over a clear in the
  // same cycle so that no overflow event can be lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovfSticky <= 1'b0;
    end else if (w_s2Load && w_flags.o) begin
      r_ovfSticky <= 1'b1;
    end else if (clr_sticky) begin
      r_ovfSticky <= 1'b0;
    end
  end

  assign in_ready   = w_inReady;
  assign out_valid  = r_outValid;
  assign out_sum    = r_outSum;
  assign out_z      = r_outFlags.z;
  assign out_s      = r_outFlags.s;
  assign out_c      = r_outFlags.c;
  assign out_p      = r_outFlags.p;
  assign out_o      = r_outFlags.o;
  assign carry_flag = r_carryFlag;
  assign ovf_sticky = r_ovfSticky;

endmodule

// File: tb/tb_addsub_flags_pipe.sv
// ---------------------------------------------------------------------------
// tb_addsub_flags_pipe
//
// Directed and randomized bench for addsub_flags_pipe at WIDTH=16, odd
// parity. Expected results come from a signed/unsigned integer model of the
// four operations, queued in acceptance order.
// ---------------------------------------------------------------------------
module tb_addsub_flags_pipe;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] sum;
    logic z;
    logic s;
    logic c;
    logic p;
    logic o;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [1:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_z, out_s, out_c, out_p, out_o;
  logic         carry_flag;
  logic         ovf_sticky;
  logic         clr_sticky;

  int   checks   = 0;
  int   failures = 0;
  res_t expQ[$];
  logic mCarry   = 1'b0;
  logic mSticky  = 1'b0;
  res_t lastOut;
  int   popCount = 0;

  always #5 clk = ~clk;

  addsub_flags_pipe #(.WIDTH(W), .PARITY_ODD(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_z      (out_z),
    .out_s      (out_s),
    .out_c      (out_c),
    .out_p      (out_p),
    .out_o      (out_o),
    .carry_flag (carry_flag),
    .ovf_sticky (ovf_sticky),
    .clr_sticky (clr_sticky)
  );

  // Reference: exact integer arithmetic, then reduce. Carry is "result did
  // not fit" for adds and "result went negative" for subtracts; overflow is
  // "signed result out of range".
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] op, input logic cIn,
                                 output logic cOut);
    longint modW = longint'(1) << W;
    longint half = longint'(1) << (W - 1);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = a[W-1] ? ua - modW : ua;
    longint sb = b[W-1] ? ub - modW : ub;
    longint ci = cIn ? 1 : 0;
    longint full;
    longint sfull;
    logic [63:0] bits;
    res_t r;
    case (op)
      2'b00:   begin full = ua + ub;      sfull = sa + sb;      cOut = (full >= modW); end
      2'b01:   begin full = ua - ub;      sfull = sa - sb;      cOut = (full < 0);     end
      2'b10:   begin full = ua + ub + ci; sfull = sa + sb + ci; cOut = (full >= modW); end
      default: begin full = ua - ub - ci; sfull = sa - sb - ci; cOut = (full < 0);     end
    endcase
    bits  = 64'(full);
    r.sum = bits[W-1:0];
    r.z   = (r.sum == 0);
    r.s   = r.sum[W-1];
    r.c   = cOut;
    r.p   = ($countones(r.sum) % 2) == 1;
    r.o   = (sfull >= half) || (sfull < -half);
    return r;
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: let inputs settle, record any handshakes that will complete
  // at the coming edge, then advance to the next falling edge.
  task automatic cycle(output bit accepted);
    res_t r;
    res_t e;
    logic co;
    #1;
    accepted = in_valid && in_ready;
    if (accepted) begin
      r = model(in_a, in_b, in_op, mCarry, co);
      mCarry  = co;
      mSticky = mSticky | r.o;
      expQ.push_back(r);
    end
    if (out_valid && out_ready) begin
      lastOut = {out_sum, out_z, out_s, out_c, out_p, out_o};
      popCount++;
      if (expQ.size() == 0) begin
        checkVal("unexpected_out", 64'(lastOut), 64'hDEAD);
      end else begin
        e = expQ.pop_front();
        checkVal("result", 64'(lastOut), 64'(e));
      end
    end
    @(negedge clk);
  endtask

  // Present a beat and hold it until accepted; in_valid stays high so that
  // consecutive calls stream without gaps.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [1:0] op, output int waited);
    bit acc;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    waited   = 0;
    acc      = 1'b0;
    while (!acc && waited < 50) begin
      cycle(acc);
      if (!acc) waited++;
    end
    if (!acc) checkVal("accept_timeout", 64'(waited), 0);
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && (expQ.size() > 0 || out_valid); i++) cycle(acc);
    checkVal("drain_empty", 64'(expQ.size()), 0);
  endtask

  task automatic clearSticky();
    bit acc;
    clr_sticky = 1'b1;
    cycle(acc);
    clr_sticky = 1'b0;
    mSticky    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit acc;
    int waited;
    int acceptedCnt;
    int popsBefore;
    logic [W-1:0] sa [4];
    logic [W-1:0] sb [4];
    logic [1:0]   sop[4];
    logic [W-1:0] edgeVals[4];

    edgeVals[0] = 16'h0000; edgeVals[1] = 16'hFFFF;
    edgeVals[2] = 16'h7FFF; edgeVals[3] = 16'h8000;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 2'b00;
    out_ready = 1'b0; clr_sticky = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    checkVal("rst_in_ready", 64'(in_ready), 0);
    checkVal("rst_outputs",
             64'({out_valid, out_sum, out_z, out_s, out_c, out_p, out_o, carry_flag, ovf_sticky}), 0);
    rst = 1'b0;
    #1;
    checkVal("in_ready_after_rst", 64'(in_ready), 1);
    @(negedge clk);

    // Latency of a single beat with no stall.
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 16'h0001; in_b = 16'h0002; in_op = 2'b00;
    cycle(acc);
    checkVal("lat_accepted", 64'(acc), 1);
    in_valid = 1'b0;
    checkVal("lat_cycle1_valid", 64'(out_valid), 0);
    cycle(acc);
    checkVal("lat_cycle2_valid", 64'(out_valid), 1);
    drain();

    // ADD wrapping to zero.
    applyStimulus(16'hFFFF, 16'h0001, 2'b00, waited);
    drain();
    checkVal("add_wrap", 64'(lastOut), 64'({16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}));
    checkVal("add_wrap_carry", 64'(carry_flag), 1);

    // Signed overflow and sticky behaviour.
    applyStimulus(16'h7FFF, 16'h0001, 2'b00, waited);
    drain();
    checkVal("add_ovf", 64'(lastOut), 64'({16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}));
    checkVal("sticky_set", 64'(ovf_sticky), 1);
    applyStimulus(16'h0001, 16'h0001, 2'b00, waited);
    drain();
    checkVal("sticky_holds", 64'(ovf_sticky), 1);
    clearSticky();
    checkVal("sticky_cleared", 64'(ovf_sticky), 0);
    applyStimulus(16'h7FFF, 16'h0001, 2'b00, waited);
    in_valid   = 1'b0;
    clr_sticky = 1'b1;
    cycle(acc);
    clr_sticky = 1'b0;
    checkVal("sticky_set_wins", 64'(ovf_sticky), 1);
    drain();
    clearSticky();

    // Carry chain, back to back.
    applyStimulus(16'hFFFF, 16'h0002, 2'b00, waited);
    applyStimulus(16'h0000, 16'h0000, 2'b10, waited);
    checkVal("adc_no_bubble_wait", 64'(waited), 0);
    drain();
    checkVal("adc_chain", 64'(lastOut), 64'({16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));

    // Borrow chain.
    applyStimulus(16'h0003, 16'h0005, 2'b01, waited);
    drain();
    checkVal("sub_borrow", 64'(lastOut), 64'({16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}));
    checkVal("sub_borrow_flag", 64'(carry_flag), 1);
    applyStimulus(16'h0005, 16'h0001, 2'b11, waited);
    drain();
    checkVal("sbb_chain", 64'(lastOut), 64'({16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));

    // Stall: four beats offered while out_ready is low for five cycles.
    for (int i = 0; i < 4; i++) begin
      sa[i] = W'($urandom); sb[i] = W'($urandom); sop[i] = 2'($urandom);
    end
    popsBefore  = popCount;
    out_ready   = 1'b0;
    acceptedCnt = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_a = sa[acceptedCnt]; in_b = sb[acceptedCnt]; in_op = sop[acceptedCnt];
      cycle(acc);
      if (acc) acceptedCnt++;
    end
    #1;
    checkVal("stall_accepted", 64'(acceptedCnt), 2);
    checkVal("stall_in_ready", 64'(in_ready), 0);
    checkVal("stall_out_valid", 64'(out_valid), 1);
    checkVal("stall_out_sum", 64'(out_sum), 64'(expQ[0].sum));
    out_ready = 1'b1;
    for (int i = 2; i < 4; i++) applyStimulus(sa[i], sb[i], sop[i], waited);
    drain();
    checkVal("stall_all_out", 64'(popCount - popsBefore), 4);

    // Randomized traffic with random backpressure and boundary operands.
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_op     = 2'($urandom);
      in_a      = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 3)] : W'($urandom);
      in_b      = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 3)] : W'($urandom);
      cycle(acc);
    end
    drain();
    checkVal("rand_carry_flag", 64'(carry_flag), 64'(mCarry));
    checkVal("rand_sticky", 64'(ovf_sticky), 64'(mSticky));

    // Reset with two beats in flight.
    out_ready   = 1'b0;
    acceptedCnt = 0;
    for (int c = 0; c < 10 && acceptedCnt < 2; c++) begin
      in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001; in_op = 2'b00;
      cycle(acc);
      if (acc) acceptedCnt++;
    end
    in_valid = 1'b0;
    checkVal("flight_accepted", 64'(acceptedCnt), 2);
    rst = 1'b1;
    expQ.delete();
    mCarry = 1'b0; mSticky = 1'b0;
    @(negedge clk);
    #1;
    checkVal("midrst_outputs",
             64'({in_ready, out_valid, out_sum, out_z, out_s, out_c, out_p, out_o, ovf_sticky}), 0);
    checkVal("midrst_carry", 64'(carry_flag), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      cycle(acc);
      checkVal("post_rst_no_valid", 64'(out_valid), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
